// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// master drives operands and out_ready; slave is the adder.
interface adder_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   y;
  logic [LW-1:0]    level;
  logic [15:0]      done_cnt;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, level, done_cnt
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, level, done_cnt
  );
endinterface

// File: rtl/adder_pipe.sv
// Handshaked adder: one register stage feeding a result FIFO.
// Define ADDER_PIPE_ASSERT_EN to compile in the embedded assertions.
module adder_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  adder_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            s1_valid;
  logic [WIDTH:0]  s1_sum;
  logic [15:0]     done_cnt;
  logic [LW:0]     occ;
  logic            in_ready;
  logic            out_valid;
  logic            accept;
  logic            pop;

  // occupancy counts the in-flight stage-1 result as already reserved
  assign occ       = {1'b0, level} + {{LW{1'b0}}, s1_valid};
  assign in_ready  = !rst && (occ < (LW+1)'(DEPTH));
  assign out_valid = (level != '0);
  assign accept    = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y         = out_valid ? mem[rd_ptr] : '0;
  assign bus.level     = level;
  assign bus.done_cnt  = done_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      done_cnt <= '0;
    end else begin
      s1_valid <= accept;
      if (accept)
        s1_sum <= {1'b0, bus.a} + {1'b0, bus.b};
      if (s1_valid)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        done_cnt <= done_cnt + 16'd1;
      end
      unique case ({s1_valid, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid)
      mem[wr_ptr] <= s1_sum;
  end

`ifdef ADDER_PIPE_ASSERT_EN
  a_y_known: assert property (
    @(posedge clk) disable iff (rst)
    out_valid |-> !$isunknown(bus.y))
    else $error("%0t y unknown: %h", $time, bus.y);

  a_stall: assert property (
    @(posedge clk) disable iff (rst)
    out_valid && !bus.out_ready |=> out_valid && $stable(bus.y))
    else $error("%0t stall unstable: ov=%b y=%h",
                $time, out_valid, bus.y);

  a_no_ovf: assert property (
    @(posedge clk) disable iff (rst)
    !(s1_valid && level == LW'(DEPTH)))
    else $error("%0t push when full: level=%0d", $time, level);

  a_level: assert property (
    @(posedge clk) disable iff (rst)
    level <= LW'(DEPTH))
    else $error("%0t level too high: %0d", $time, level);
`endif
endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe with a queue-based reference model.
// Per-cycle compare on negedge plus literal spot checks.
module tb_adder_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  adder_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  adder_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [8:0]  q[$];
  bit          pend_v;
  logic [8:0]  pend_d;
  logic [15:0] m_cnt;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40)
        $display("FAIL %s at %0t: got %0h expected %0h",
                 name, $time, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return !rst && (q.size() + int'(pend_v) < DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      pend_v = 1'b0;
      m_cnt  = '0;
    end else begin
      bit acc;
      acc = bus.in_valid && m_ready();
      if (q.size() != 0 && bus.out_ready) begin
        void'(q.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (pend_v)
        q.push_back(pend_d);
      pend_v = acc;
      if (acc)
        pend_d = 9'(bus.a) + 9'(bus.b);
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(bus.in_ready), 32'(m_ready()));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("y", 32'(bus.y), (q.size() != 0) ? 32'(q[0]) : 32'd0);
    check("level", 32'(bus.level), 32'(q.size()));
    check("done_cnt", 32'(bus.done_cnt), 32'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [7:0] x, logic [7:0] z);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = z;
  endtask

  task automatic drain();
    drive(1'b0, 8'h00, 8'h00);
    bus.out_ready = 1'b1;
    repeat (DEPTH + 3) step();
  endtask

  initial begin
    int acc;
    drive(1'b0, 8'h00, 8'h00);
    bus.out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) step();
    rst = 1'b0;

    // single pair
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h0F, 8'h01);
    step();
    drive(1'b0, 8'h00, 8'h00);
    check("single_lat1", 32'(bus.out_valid), 32'd0);
    step();
    check("single_ov", 32'(bus.out_valid), 32'd1);
    check("single_y", 32'(bus.y), 32'h010);
    step();
    check("single_cnt", 32'(bus.done_cnt), 32'd1);
    check("single_empty", 32'(bus.out_valid), 32'd0);

    // carry, back to back
    drive(1'b1, 8'hFF, 8'h01);
    check("carry_rdy0", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b1, 8'hFF, 8'hFF);
    check("carry_rdy1", 32'(bus.in_ready), 32'd1);
    step();
    check("carry_y0", 32'(bus.y), 32'h100);
    drive(1'b1, 8'h00, 8'h00);
    check("carry_rdy2", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 8'h00, 8'h00);
    check("carry_y1", 32'(bus.y), 32'h1FE);
    step();
    check("carry_y2", 32'(bus.y), 32'h000);
    check("carry_ov2", 32'(bus.out_valid), 32'd1);
    drain();

    // back-pressure and full
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h10 + i), 8'h20);
      if (bus.in_ready) acc++;
      step();
    end
    drive(1'b0, 8'h00, 8'h00);
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_level", 32'(bus.level), 32'd4);
    check("bp_ready", 32'(bus.in_ready), 32'd0);
    check("bp_y", 32'(bus.y), 32'h030);
    step();
    check("bp_y_hold", 32'(bus.y), 32'h030);
    bus.out_ready = 1'b1;
    step();
    check("bp_ready_back", 32'(bus.in_ready), 32'd1);
    check("bp_y_next", 32'(bus.y), 32'h031);
    drain();

    // overlapped push/pop at level 2
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(i * 7), 8'(i + 100));
      step();
    end
    check("ov_level_start", 32'(bus.level), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(i * 29 + 3), 8'(255 - i * 11));
      step();
      check("ov_level", 32'(bus.level), 32'd2);
    end
    drain();

    // reset with level 3 and stage 1 busy
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i + 1), 8'h40);
      step();
    end
    drive(1'b0, 8'h00, 8'h00);
    check("pre_rst_level", 32'(bus.level), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    check("rst_async_rdy", 32'(bus.in_ready), 32'd0);
    check("rst_async_ov", 32'(bus.out_valid), 32'd0);
    check("rst_async_y", 32'(bus.y), 32'd0);
    check("rst_async_lvl", 32'(bus.level), 32'd0);
    check("rst_async_cnt", 32'(bus.done_cnt), 32'd0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h02, 8'h03);
    step();
    drive(1'b0, 8'h00, 8'h00);
    step();
    check("post_rst_y", 32'(bus.y), 32'h005);
    check("post_rst_lvl", 32'(bus.level), 32'd1);
    drain();

    // counter wrap after 65536 pops from reset
    #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 8'(i), 8'(i >> 8));
      step();
    end
    drive(1'b0, 8'h00, 8'h00);
    step();
    check("wrap_ffff", 32'(bus.done_cnt), 32'hFFFF);
    step();
    check("wrap_zero", 32'(bus.done_cnt), 32'h0000);
    check("wrap_empty", 32'(bus.out_valid), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
